// File: rtl/id_pipe_stage_if.sv
// Decode-stage boundary bundle: IF/ID instruction handshake, writeback, hazard inputs and the
// registered ID/EX output. master is the surrounding pipeline, slave is the decode stage.
interface id_pipe_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned RA = $clog2(NREGS);

  logic            halted;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc4_in;
  logic            wb_we;
  logic [RA-1:0]   wb_num;
  logic [XLEN-1:0] wb_data;
  logic            ex_load;
  logic [RA-1:0]   ex_dest;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] imm_ext;
  logic [RA-1:0]   dest_num;
  logic            reg_write;
  logic [5:0]      opcode;
  logic [5:0]      func;
  logic [RA-1:0]   rs_num;
  logic [RA-1:0]   rt_num;
  logic [XLEN-1:0] pc4_out;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output halted, in_valid, inst, pc4_in, wb_we, wb_num, wb_data, ex_load, ex_dest, flush,
           out_ready,
    input  in_ready, out_valid, rs_data, rt_data, imm_ext, dest_num, reg_write, opcode, func,
           rs_num, rt_num, pc4_out, stall_count
  );

  modport slave (
    input  halted, in_valid, inst, pc4_in, wb_we, wb_num, wb_data, ex_load, ex_dest, flush,
           out_ready,
    output in_ready, out_valid, rs_data, rt_data, imm_ext, dest_num, reg_write, opcode, func,
           rs_num, rt_num, pc4_out, stall_count
  );
endinterface

// File: rtl/id_pipe_stage.sv
// MIPS decode stage: register file, immediate/destination decode, load-use stall detection and
// a registered ID/EX output with valid/ready handshake, flush and a saturating stall counter.
module id_pipe_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input logic            clk,
  input logic            rst_b,
  id_pipe_stage_if.slave bus
);
  localparam int unsigned RA = $clog2(NREGS);

  logic [XLEN-1:0] rf_q [NREGS];

  logic [5:0]      op;
  logic [5:0]      fn;
  logic [RA-1:0]   rs_idx;
  logic [RA-1:0]   rt_idx;
  logic [RA-1:0]   rd_idx;
  logic            is_store;
  logic            is_branch;
  logic            uses_rt;
  logic [RA-1:0]   dest_d;
  logic            reg_write_d;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            stall;
  logic            adv;

  logic             out_valid_q;
  logic [XLEN-1:0]  rs_data_q;
  logic [XLEN-1:0]  rt_data_q;
  logic [XLEN-1:0]  imm_ext_q;
  logic [RA-1:0]    dest_num_q;
  logic             reg_write_q;
  logic [5:0]       opcode_q;
  logic [5:0]       func_q;
  logic [RA-1:0]    rs_num_q;
  logic [RA-1:0]    rt_num_q;
  logic [XLEN-1:0]  pc4_out_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Shift amount is consumed downstream from func/opcode decode, not here.
  logic unused_shamt;
  assign unused_shamt = ^bus.inst[10:6];

  assign op     = bus.inst[31:26];
  assign fn     = bus.inst[5:0];
  assign rs_idx = bus.inst[21 +: RA];
  assign rt_idx = bus.inst[16 +: RA];
  assign rd_idx = bus.inst[11 +: RA];

  always_comb begin
    is_store    = (op == 6'h2B) || (op == 6'h29) || (op == 6'h28);
    is_branch   = (op == 6'h04) || (op == 6'h05);
    uses_rt     = (op == 6'h00) || is_branch || is_store;

    dest_d = rt_idx;
    if (op == 6'h00) begin
      dest_d = rd_idx;
    end else if (op == 6'h03) begin
      dest_d = RA'(NREGS - 1);
    end

    reg_write_d = !(is_store || is_branch || (op == 6'h02) ||
                    ((op == 6'h00) && (fn == 6'h08)) || (bus.inst == 32'h0));

    if ((op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E)) begin
      imm_d = {{(XLEN-16){1'b0}}, bus.inst[15:0]};
    end else begin
      imm_d = {{(XLEN-16){bus.inst[15]}}, bus.inst[15:0]};
    end
  end

  // Register 0 is hardwired; a same-cycle writeback can be forwarded to either read port.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_idx != '0) begin
      if ((WB_BYPASS != 0) && bus.wb_we && (bus.wb_num == rs_idx)) begin
        rs_val = bus.wb_data;
      end else begin
        rs_val = rf_q[rs_idx];
      end
    end
    if (rt_idx != '0) begin
      if ((WB_BYPASS != 0) && bus.wb_we && (bus.wb_num == rt_idx)) begin
        rt_val = bus.wb_data;
      end else begin
        rt_val = rf_q[rt_idx];
      end
    end
  end

  assign stall = bus.in_valid && bus.ex_load && (bus.ex_dest != '0) &&
                 ((bus.ex_dest == rs_idx) || (uses_rt && (bus.ex_dest == rt_idx)));
  assign adv   = (!out_valid_q || bus.out_ready) && !bus.halted;

  // A flushed input is consumed and dropped, so the stage always reports ready then.
  assign bus.in_ready = bus.flush || (adv && !stall);

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_num != '0) && !bus.halted) begin
      rf_q[bus.wb_num] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      out_valid_q <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_ext_q   <= '0;
      dest_num_q  <= '0;
      reg_write_q <= 1'b0;
      opcode_q    <= '0;
      func_q      <= '0;
      rs_num_q    <= '0;
      rt_num_q    <= '0;
      pc4_out_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (adv) begin
        if (stall) begin
          out_valid_q <= 1'b0;
        end else if (bus.in_valid) begin
          out_valid_q <= 1'b1;
          rs_data_q   <= rs_val;
          rt_data_q   <= rt_val;
          imm_ext_q   <= imm_d;
          dest_num_q  <= dest_d;
          reg_write_q <= reg_write_d;
          opcode_q    <= op;
          func_q      <= fn;
          rs_num_q    <= rs_idx;
          rt_num_q    <= rt_idx;
          pc4_out_q   <= bus.pc4_in;
        end else begin
          out_valid_q <= 1'b0;
        end
      end

      if (stall && adv && !bus.flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.rs_data     = rs_data_q;
  assign bus.rt_data     = rt_data_q;
  assign bus.imm_ext     = imm_ext_q;
  assign bus.dest_num    = dest_num_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.opcode      = opcode_q;
  assign bus.func        = func_q;
  assign bus.rs_num      = rs_num_q;
  assign bus.rt_num      = rt_num_q;
  assign bus.pc4_out     = pc4_out_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: doc/id_pipe_stage.md
Name: id_pipe_stage

Overview:
Parametrised decode stage for the pipelined MIPS core. It sits between IF and EX and contains:
- the register file,
- immediate extension and destination/write-enable decode,
- load-use hazard detection,
- a registered ID/EX output with valid/ready handshake and flush.

It generalises the single-cycle decode stage with configurable width and register count, writeback bypass, stall/bubble insertion and a stall counter.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, register count (power of two); RA = log2(NREGS)
WB_BYPASS, 1, 1 = same-cycle writeback data forwarded to reads
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous, active-high reset
halted  input  1  freezes register-file writes and stage advance
in_valid  input  1  IF/ID holds valid instruction
in_ready  output  1  stage accepts instruction this cycle
inst  input  32  instruction word
pc4_in  input  XLEN  PC+4 of instruction
wb_we  input  1  writeback enable
wb_num  input  RA  writeback register
wb_data  input  XLEN  writeback data
ex_load  input  1  instruction in EX is a valid load
ex_dest  input  RA  destination of instruction in EX
flush  input  1  squash ID/EX contents and current input
out_valid  output  1  ID/EX register valid
out_ready  input  1  EX accepts ID/EX contents
rs_data  output  XLEN  registered rs operand
rt_data  output  XLEN  registered rt operand
imm_ext  output  XLEN  registered extended immediate
dest_num  output  RA  registered destination register
reg_write  output  1  registered write enable
opcode  output  6  registered inst[31:26]
func  output  6  registered inst[5:0]
rs_num  output  RA  registered rs index (for forwarding)
rt_num  output  RA  registered rt index
pc4_out  output  XLEN  registered PC+4
stall_count  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (asynchronous, rst_b=1): all registers clear; all outputs 0, including out_valid and stall_count. in_ready is combinational and may be 1 during reset.
- Register file: NREGS x XLEN. Register 0 always reads 0.
  - Write at posedge when wb_we && wb_num!=0 && !halted.
  - Reads combinational from inst[25:21] and inst[20:16], using the low RA bits.
  - WB_BYPASS=1: a read of wb_num (≠0) while wb_we returns wb_data in the same cycle.
  - WB_BYPASS=0: the read returns the old value.
- Decode, combinational, latched into ID/EX:
  - dest_num: rd (inst[15:11]) for opcode 0; NREGS-1 for opcode 3 (jal); rt otherwise.
  - reg_write = 0 for:
    - sw/sh/sb (0x2B/0x29/0x28)
    - beq/bne (0x04/0x05)
    - j (0x02)
    - opcode 0 with func 0x08 (jr)
    - all-zero instruction (nop)
    - reg_write = 1 otherwise.
  - imm_ext: zero-extended for andi/ori/xori (0x0C/0x0D/0x0E); sign-extended from bit 15 otherwise.
  - uses_rt = 1 for opcode 0, beq, bne and stores.
- Load-use hazard: stall = in_valid && ex_load && ex_dest!=0 && (ex_dest==rs || (uses_rt && ex_dest==rt)).
- Advance: adv = (!out_valid || out_ready) && !halted.
- in_ready = adv && !stall, or 1 when flush (input discarded).
- ID/EX update at posedge, priority order:
  1. flush: out_valid←0, other fields hold.
  2. adv && stall: out_valid←0 (bubble), fields hold.
  3. adv && in_valid: load all fields, out_valid←1.
  4. adv && !in_valid: out_valid←0.
  5. Otherwise hold all fields.
- Fields never change while out_valid && !out_ready.
- stall_count increments once per cycle in which stall && adv && !flush; saturates at all-ones.
- halted=1: no register-file write, no ID/EX change, in_ready=0 (flush still clears out_valid).
- Flush and stall in the same cycle: flush wins; stall_count does not increment.

Test Plan:
- Reset mid-operation: load ID/EX, assert rst_b=1 asynchronously → out_valid=0, stall_count=0, and all registers read 0 after release.
- Writeback bypass: wb_we=1, wb_num=5, wb_data=0xDEADBEEF; inst=add $7,$5,$0 same cycle → rs_data=0xDEADBEEF next cycle (WB_BYPASS=1), 0 with WB_BYPASS=0; write to $0 → $0 stays 0.
- Load-use: ex_load=1, ex_dest=8; inst=add $9,$8,$1 for 2 cycles → in_ready=0, bubble (out_valid=0) each cycle, stall_count=2. Drop ex_load → instruction issues, out_valid=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid → in_ready=0, outputs stable. Raise out_ready → next instruction loaded.
- Decode: ori $3,$4,0x8000 → imm_ext=0x00008000, dest_num=3, reg_write=1. addi with 0x8000 → imm_ext=0xFFFF8000. jal → dest_num=31. sw → reg_write=0.
- Flush with stall: ex_load hazard plus flush=1 → out_valid=0, in_ready=1, stall_count unchanged.
